// File: rtl/cordic_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_iter : iterative rotation-mode CORDIC (sin/cos/residual), optional
//               CORDIC_QUAD_EN full-circle folding.            Rev 1.0
// ---------------------------------------------------------------------------
module cordic_iter #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] angle,
  output logic signed [WIDTH-1:0] sin,
  output logic signed [WIDTH-1:0] cos,
  output logic signed [WIDTH-1:0] resid,
  output logic                    busy,
  output logic                    done
);

  localparam int  ZW     = WIDTH + 2;
  localparam int  IW     = (ITER > 1) ? $clog2(ITER) : 1;
  localparam real K_GAIN = 0.6072529350;

  function automatic logic signed [ZW-1:0] to_fix(input real v);
    return ZW'(longint'(v));
  endfunction

  // Beyond i=16 the cubic term of atan lies far below the finest z LSB.
  function automatic real atan_pow2(input int k);
    case (k)
      0:       return 0.7853981633974483;
      1:       return 0.4636476090008061;
      2:       return 0.24497866312686414;
      3:       return 0.12435499454676144;
      4:       return 0.06241880999595735;
      5:       return 0.031239833430268277;
      6:       return 0.015623728620476831;
      7:       return 0.007812341060101111;
      8:       return 0.0039062301319669718;
      9:       return 0.0019531225164788188;
      10:      return 0.0009765621895593195;
      11:      return 0.0004882812111948983;
      12:      return 0.00024414062014936177;
      13:      return 0.00012207031189367021;
      14:      return 6.103515617420877e-05;
      15:      return 3.0517578115526096e-05;
      16:      return 1.5258789061315762e-05;
      default: return 2.0 ** (-k);
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] to_out(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1])
      return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return v[WIDTH-1:0];
  endfunction

  localparam logic signed [ZW-1:0] X_INIT = to_fix(K_GAIN * (2.0 ** (WIDTH - 2))) <<< 2;

  logic signed [ZW-1:0] atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic signed [ZW-1:0] ATAN_G = to_fix(atan_pow2(g) * (2.0 ** (WIDTH - 1)));
    assign atan_tab[g] = ATAN_G;
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, next_state;
  logic signed [ZW-1:0] x, y, z;
  logic signed [ZW-1:0] x_sh, y_sh, x_nxt, y_nxt, z_nxt, cap_z;
  logic signed [WIDTH:0] sin_ext, cos_ext;
  logic [IW-1:0]        i;
  logic                 capture;

`ifdef CORDIC_QUAD_EN
  localparam real PI = 3.14159265358979;
  localparam logic signed [ZW-1:0] PI_Z      = to_fix(PI * (2.0 ** (WIDTH - 1)));
  localparam logic signed [ZW-1:0] HALF_PI_A = to_fix(PI * (2.0 ** (WIDTH - 4)));
  localparam logic signed [ZW-1:0] HALF_PI_Z = HALF_PI_A <<< 2;
  logic cap_flip, flip;
`endif

  assign busy    = (state == RUN);
  assign capture = start && (state != RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (i == IW'(ITER - 1)) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Angle arrives in Q3.(W-3); two guard LSBs turn it into the internal z format.
  always_comb begin
    cap_z = {angle, 2'b00};
`ifdef CORDIC_QUAD_EN
    cap_flip = 1'b0;
    if (cap_z > HALF_PI_Z) begin
      cap_z    = cap_z - PI_Z;
      cap_flip = 1'b1;
    end else if (cap_z < -HALF_PI_Z) begin
      cap_z    = cap_z + PI_Z;
      cap_flip = 1'b1;
    end
`endif
  end

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    if (!z[ZW-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_tab[i];
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_tab[i];
    end
  end

  always_comb begin
    sin_ext = {y[ZW-1], y[ZW-1:2]};
    cos_ext = {x[ZW-1], x[ZW-1:2]};
`ifdef CORDIC_QUAD_EN
    if (flip) begin
      sin_ext = -sin_ext;
      cos_ext = -cos_ext;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      i     <= '0;
      sin   <= '0;
      cos   <= '0;
      resid <= '0;
      done  <= 1'b0;
`ifdef CORDIC_QUAD_EN
      flip  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (capture) begin
        x <= X_INIT;
        y <= '0;
        z <= cap_z;
        i <= '0;
`ifdef CORDIC_QUAD_EN
        flip <= cap_flip;
`endif
      end else if (state == RUN) begin
        x <= x_nxt;
        y <= y_nxt;
        z <= z_nxt;
        i <= i + 1'b1;
      end
      // Results of the finished operation land while a back-to-back capture reloads x/y/z.
      if (state == DONE) begin
        sin   <= to_out(sin_ext);
        cos   <= to_out(cos_ext);
        resid <= to_out({z[ZW-1], z[ZW-1:2]});
        done  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter.sv
`default_nettype none
// tb_cordic_iter : scoreboard bench for cordic_iter (WIDTH=16, ITER=14).
module tb_cordic_iter;
  localparam int WIDTH = 16;
  localparam int ITER  = 14;

  typedef struct { int es; int ec; int due; } exp_t;
  typedef struct { int cyc; int s; int c; int r; } ev_t;

  logic                    clock   = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    start   = 1'b0;
  logic signed [WIDTH-1:0] angle   = '0;
  logic signed [WIDTH-1:0] dut_sin, dut_cos, dut_resid;
  logic                    busy, done;

  int   cyc      = 0;
  int   busy_cnt = 0;
  int   total    = 0;
  int   bad      = 0;
  int   rd       = 0;
  exp_t sb[$];
  ev_t  ev[$];
  ev_t  mon_e;

  cordic_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .angle  (angle),
    .sin    (dut_sin),
    .cos    (dut_cos),
    .resid  (dut_resid),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      mon_e.cyc = cyc;
      mon_e.s   = int'(dut_sin);
      mon_e.c   = int'(dut_cos);
      mon_e.r   = int'(dut_resid);
      ev.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input int obs, input int req, input int tol);
    int diff;
    diff = obs - req;
    if (diff < 0) diff = -diff;
    total++;
    assert (diff <= tol) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, req, tol);
    end
  endtask

  // Reference values come from real trig of the commanded angle.
  task automatic push_exp(input int a, input int k);
    exp_t e;
    real  r;
    r     = real'(a) / 8192.0;
    e.es  = int'($sin(r) * 16384.0);
    e.ec  = int'($cos(r) * 16384.0);
    e.due = cyc + ITER + 2 + (ITER + 1) * k;
    sb.push_back(e);
  endtask

  task automatic wait_events(input int n);
    int lim;
    lim = 40 * n;
    while (ev.size() < rd + n && lim > 0) begin
      @(negedge clock);
      lim--;
    end
    total++;
    assert (ev.size() >= rd + n) else begin
      bad++;
      $error("FAIL done_timeout observed=%0d expected=%0d", ev.size() - rd, n);
    end
  endtask

  task automatic check_next();
    exp_t e;
    ev_t  v;
    if (sb.size() == 0 || rd >= ev.size()) return;
    e = sb.pop_front();
    v = ev[rd];
    rd++;
    check("latency", v.cyc, e.due, 0);
    check("sin", v.s, e.es, 4);
    check("cos", v.c, e.ec, 4);
    check("resid", v.r, 0, 4);
  endtask

  task automatic run_op(input int a);
    int b0;
    b0 = busy_cnt;
    push_exp(a, 0);
    start = 1'b1;
    angle = 16'(a);
    @(negedge clock);
    start = 1'b0;
    angle = 16'($urandom);
    wait_events(1);
    check_next();
    check("busy_len", busy_cnt - b0, ITER, 0);
  endtask

  initial begin
    int b0;
    repeat (3) @(negedge clock);
    check("rst_sin", int'(dut_sin), 0, 0);
    check("rst_cos", int'(dut_cos), 0, 0);
    check("rst_resid", int'(dut_resid), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(0);
    run_op(12868);
    run_op(-4289);
    run_op(4289);
    run_op(-12868);
    run_op(2000);

    // Extra start requests during RUN must be ignored.
    b0 = busy_cnt;
    push_exp(6434, 0);
    start = 1'b1;
    angle = 16'(6434);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1;
    angle = 16'(-9000);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1;
    angle = 16'(3000);
    @(negedge clock);
    start = 1'b0;
    wait_events(1);
    check_next();
    check("busy_len_ign", busy_cnt - b0, ITER, 0);
    repeat (20) @(negedge clock);
    check("extra_done", ev.size() - rd, 0, 0);

    // Start held high: back-to-back operations every ITER+1 clocks.
    push_exp(4289, 0);
    push_exp(4289, 1);
    push_exp(4289, 2);
    start = 1'b1;
    angle = 16'(4289);
    repeat (35) @(negedge clock);
    start = 1'b0;
    wait_events(3);
    check_next();
    check_next();
    check_next();
    repeat (20) @(negedge clock);
    check("extra_done_hold", ev.size() - rd, 0, 0);

    // Reset in the middle of RUN aborts the operation.
    start = 1'b1;
    angle = 16'(-6434);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_sin", int'(dut_sin), 0, 0);
    check("abort_cos", int'(dut_cos), 0, 0);
    check("abort_resid", int'(dut_resid), 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check("abort_no_done", ev.size() - rd, 0, 0);

    run_op(-4289);
    repeat (10) @(negedge clock);
    check("hold_sin", int'(dut_sin), -8192, 4);
    check("hold_cos", int'(dut_cos), 14189, 4);

`ifdef CORDIC_QUAD_EN
    run_op(19302);
    run_op(-19302);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 Parameter WIDTH, default 16; angle and result width in bits; legal range 12..32.
REQ-002 Parameter ITER, default 14; micro-rotations per operation; legal range 1..WIDTH-2.
REQ-003 Port clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request: begin an operation on angle.
REQ-006 Port angle  input  WIDTH  target angle; signed Q3.(WIDTH-3) radians.
REQ-007 Port sin  output  WIDTH  sine result; signed Q2.(WIDTH-2).
REQ-008 Port cos  output  WIDTH  cosine result; signed Q2.(WIDTH-2).
REQ-009 Port resid  output  WIDTH  residual angle z; same format as angle.
REQ-010 Port busy  output  1  high while iterating.
REQ-011 Port done  output  1  one-cycle pulse when sin/cos/resid become valid.

Function
REQ-012 The FSM shall have three states: IDLE, RUN and DONE.
REQ-013 When start=1 in IDLE or DONE, the block shall capture angle and enter RUN.
REQ-014 On capture: x=K·2^(WIDTH-2), with K=0.6072529350 rounded to nearest; y=0; z=angle; iteration counter i=0.
REQ-015 Internal x/y/z shall be WIDTH+2 bits signed, with 2 guard LSBs below the output format.
REQ-016 Each RUN cycle with d=+1 if z>=0 else -1: x'=x-d·(y>>>i); y'=y+d·(x>>>i); z'=z-d·atan(2^-i); i'=i+1.
REQ-017 atan(2^-i) shall come from an internal constant table rounded to nearest in the internal z format, for i=0..ITER-1.
REQ-018 After exactly ITER RUN cycles, the FSM shall go to DONE and register outputs (guard bits truncated, saturated to the WIDTH signed range).
REQ-019 done shall be 1 only in the single cycle after the last iteration.
REQ-020 Latency from the start edge to the done-high cycle shall be ITER+1 clocks.
REQ-021 busy shall equal 1 exactly while in RUN.
REQ-022 start while in RUN shall be ignored; the running operation shall be unaffected.
REQ-023 DONE shall return to IDLE on the next cycle unless start=1 (back-to-back accepted).
REQ-024 sin/cos/resid shall hold their last values until the next operation completes.
REQ-025 angle shall be sampled only at capture; later changes have no effect.

Reset
REQ-026 reset_n=0 shall immediately force IDLE, with sin, cos, resid, busy, done, x, y, z and i all 0.
REQ-027 Reset asserted mid-RUN shall abort the operation; no done pulse shall follow.
REQ-028 After reset release, the first rising edge with start=1 shall begin a new operation normally.

Configuration
REQ-029 Macro CORDIC_QUAD_EN shall enable full-circle angle support.
REQ-030 With CORDIC_QUAD_EN defined:
- angle > pi/2 is replaced by angle-pi at capture, and angle < -pi/2 by angle+pi.
- a flip flag is recorded when either substitution occurs.
- if the flip flag is set, sin and cos are negated when outputs are registered.
- latency is unchanged.
REQ-031 Without CORDIC_QUAD_EN, angle shall be used as-is; results for |angle| > pi/2 are unspecified; no flip logic shall exist.

Verification
REQ-032 WIDTH=16, ITER=14, angle=0 -> done after 15 clocks; cos=16384±4, sin=0±4.
REQ-033 angle=12868 (pi/2) -> sin=16384±4, cos=0±4; angle=-4289 (-pi/6) -> sin=-8192±4, cos=14189±4.
REQ-034 start pulsed again at cycles 3 and 8 of RUN -> exactly one done pulse, 15 clocks after the first start; busy high for 14 cycles.
REQ-035 start held high continuously with angle=4289 -> done every 15 clocks; sin=8192±4 each time.
REQ-036 reset_n low at RUN cycle 5 -> all outputs 0 at once, no done pulse; a later start completes normally.
REQ-037 CORDIC_QUAD_EN defined, angle=19302 (3pi/4) -> sin=11585±4, cos=-11585±4; undefined build checks only in-range angles.
